// File: rtl/fnd_view_scheduler.sv
// rtl/fnd_view_scheduler.sv - FND display owner arbitration (watch/stopwatch/alarm), page select and blink.
// Optional FND_AUTO_PAGE_EN: periodic page toggle while the watch owns the display.
module fnd_view_scheduler #(
  parameter int ALARM_HOLD_MS  = 3000,
  parameter int BLINK_HALF_MS  = 500,
  parameter int PAGE_PERIOD_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1khz,
  input  logic       btn_mode,
  input  logic       btn_page,
  input  logic       alarm_req,
  output logic       alarm_gnt,
  input  logic [6:0] w_msec,
  input  logic [5:0] w_sec,
  input  logic [5:0] w_min,
  input  logic [4:0] w_hour,
  input  logic [6:0] s_msec,
  input  logic [5:0] s_sec,
  input  logic [5:0] s_min,
  input  logic [4:0] s_hour,
  input  logic [5:0] a_min,
  input  logic [4:0] a_hour,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       page,
  output logic [1:0] owner,
  output logic       blank
);

  typedef enum logic [1:0] {
    S_WATCH     = 2'd0,
    S_STOPWATCH = 2'd1,
    S_ALARM     = 2'd2
  } state_t;

  localparam int HOLD_W  = $clog2(ALARM_HOLD_MS + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_MS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(ALARM_HOLD_MS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_MS - 1);

  state_t state, state_d;
  state_t ret, ret_d;
  logic   page_d, page_save, page_save_d, blank_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic [BLINK_W-1:0] blink_cnt, blink_d;

`ifdef FND_AUTO_PAGE_EN
  localparam int PC_W = $clog2(PAGE_PERIOD_MS + 1);
  localparam logic [PC_W-1:0] PAGE_LAST = PC_W'(PAGE_PERIOD_MS - 1);
  logic [PC_W-1:0] page_cnt, page_cnt_d;
`else
  localparam int unused_page_period = PAGE_PERIOD_MS;
`endif

  always_comb begin
    state_d     = state;
    ret_d       = ret;
    page_d      = page;
    page_save_d = page_save;
    hold_d      = hold_cnt;
    blink_d     = blink_cnt;
    blank_d     = blank;
`ifdef FND_AUTO_PAGE_EN
    page_cnt_d  = page_cnt;
`endif
    case (state)
      S_WATCH, S_STOPWATCH: begin
        // Alarm preempts; any button arriving with it is dropped.
        if (alarm_req) begin
          state_d     = S_ALARM;
          ret_d       = state;
          page_save_d = page;
          page_d      = 1'b1;
          hold_d      = '0;
          blink_d     = '0;
          blank_d     = 1'b0;
        end else if (btn_mode) begin
          state_d = (state == S_WATCH) ? S_STOPWATCH : S_WATCH;
          page_d  = 1'b0;
`ifdef FND_AUTO_PAGE_EN
          page_cnt_d = '0;
`endif
        end else if (btn_page) begin
          page_d = ~page;
`ifdef FND_AUTO_PAGE_EN
          page_cnt_d = '0;
`endif
        end
`ifdef FND_AUTO_PAGE_EN
        else if (state == S_WATCH && tick_1khz) begin
          if (page_cnt == PAGE_LAST) begin
            page_d     = ~page;
            page_cnt_d = '0;
          end else begin
            page_cnt_d = page_cnt + 1'b1;
          end
        end
`endif
      end
      S_ALARM: begin
        if (hold_cnt == HOLD_MAX && !alarm_req) begin
          state_d = ret;
          page_d  = page_save;
          blank_d = 1'b0;
          blink_d = '0;
          hold_d  = '0;
`ifdef FND_AUTO_PAGE_EN
          page_cnt_d = '0;
`endif
        end else if (tick_1khz) begin
          if (hold_cnt != HOLD_MAX) hold_d = hold_cnt + 1'b1;
          if (blink_cnt == BLINK_LAST) begin
            blink_d = '0;
            blank_d = ~blank;
          end else begin
            blink_d = blink_cnt + 1'b1;
          end
        end
      end
      default: state_d = S_WATCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_WATCH;
      ret       <= S_WATCH;
      page      <= 1'b0;
      page_save <= 1'b0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      blank     <= 1'b0;
      alarm_gnt <= 1'b0;
      owner     <= 2'd0;
      msec      <= '0;
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
`ifdef FND_AUTO_PAGE_EN
      page_cnt  <= '0;
`endif
    end else begin
      state     <= state_d;
      ret       <= ret_d;
      page      <= page_d;
      page_save <= page_save_d;
      hold_cnt  <= hold_d;
      blink_cnt <= blink_d;
      blank     <= blank_d;
      alarm_gnt <= (state_d == S_ALARM);
      owner     <= state_d;
`ifdef FND_AUTO_PAGE_EN
      page_cnt  <= page_cnt_d;
`endif
      // Mux on the next owner so data and owner change on the same edge.
      case (state_d)
        S_STOPWATCH: begin
          msec <= s_msec;
          sec  <= s_sec;
          min  <= s_min;
          hour <= s_hour;
        end
        S_ALARM: begin
          msec <= '0;
          sec  <= '0;
          min  <= a_min;
          hour <= a_hour;
        end
        default: begin
          msec <= w_msec;
          sec  <= w_sec;
          min  <= w_min;
          hour <= w_hour;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_view_scheduler.sv
// tb/tb_fnd_view_scheduler.sv - randomized bench for fnd_view_scheduler against an ownership/tick-count model.
module tb_fnd_view_scheduler;

  localparam int HOLD   = 5;
  localparam int HALF   = 2;
  localparam int PERIOD = 4;
`ifdef FND_AUTO_PAGE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic tick_1khz, btn_mode, btn_page, alarm_req, alarm_gnt;
  logic [6:0] w_msec, s_msec, msec;
  logic [5:0] w_sec, w_min, s_sec, s_min, a_min, sec, min;
  logic [4:0] w_hour, s_hour, a_hour, hour;
  logic page, blank;
  logic [1:0] owner;

  fnd_view_scheduler #(
    .ALARM_HOLD_MS(HOLD), .BLINK_HALF_MS(HALF), .PAGE_PERIOD_MS(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .tick_1khz(tick_1khz), .btn_mode(btn_mode),
    .btn_page(btn_page), .alarm_req(alarm_req), .alarm_gnt(alarm_gnt),
    .w_msec(w_msec), .w_sec(w_sec), .w_min(w_min), .w_hour(w_hour),
    .s_msec(s_msec), .s_sec(s_sec), .s_min(s_min), .s_hour(s_hour),
    .a_min(a_min), .a_hour(a_hour),
    .msec(msec), .sec(sec), .min(min), .hour(hour),
    .page(page), .owner(owner), .blank(blank)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  string phase = "init";
  bit hold_data = 1'b0;

  // Model: who owns the display, ticks seen since alarm entry, ticks seen in watch.
  int m_owner, m_ret, m_page, m_saved, m_at, m_pc;
  int e_msec, e_sec, e_min, e_hour;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d expected %0d", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_ret = 0; m_page = 0; m_saved = 0; m_at = 0; m_pc = 0;
    e_msec = 0; e_sec = 0; e_min = 0; e_hour = 0;
  endtask

  task automatic model_step();
    if (m_owner != 2) begin
      if (alarm_req) begin
        m_ret = m_owner; m_saved = m_page; m_page = 1; m_owner = 2; m_at = 0;
      end else if (btn_mode) begin
        m_owner = 1 - m_owner; m_page = 0; m_pc = 0;
      end else if (btn_page) begin
        m_page = 1 - m_page; m_pc = 0;
      end else if (AUTO && m_owner == 0 && tick_1khz) begin
        m_pc++;
        if (m_pc % PERIOD == 0) m_page = 1 - m_page;
      end
    end else begin
      if (m_at >= HOLD && !alarm_req) begin
        m_owner = m_ret; m_page = m_saved; m_pc = 0;
      end else if (tick_1khz) begin
        m_at++;
      end
    end
    case (m_owner)
      0: begin e_msec = w_msec; e_sec = w_sec; e_min = w_min; e_hour = w_hour; end
      1: begin e_msec = s_msec; e_sec = s_sec; e_min = s_min; e_hour = s_hour; end
      default: begin e_msec = 0; e_sec = 0; e_min = a_min; e_hour = a_hour; end
    endcase
  endtask

  task automatic compare_all();
    check_val("owner", owner, m_owner);
    check_val("gnt", alarm_gnt, (m_owner == 2) ? 1 : 0);
    check_val("page", page, m_page);
    check_val("blank", blank, (m_owner == 2) ? (m_at / HALF) % 2 : 0);
    check_val("msec", msec, e_msec);
    check_val("sec", sec, e_sec);
    check_val("min", min, e_min);
    check_val("hour", hour, e_hour);
  endtask

  task automatic cycle(input logic req, input logic bm, input logic bp, input logic tk);
    alarm_req = req; btn_mode = bm; btn_page = bp; tick_1khz = tk;
    if (!hold_data) begin
      w_msec = 7'($urandom_range(0, 99)); w_sec = 6'($urandom_range(0, 59));
      w_min  = 6'($urandom_range(0, 59)); w_hour = 5'($urandom_range(0, 23));
      s_msec = 7'($urandom_range(0, 99)); s_sec = 6'($urandom_range(0, 59));
      s_min  = 6'($urandom_range(0, 59)); s_hour = 5'($urandom_range(0, 23));
      a_min  = 6'($urandom_range(0, 59)); a_hour = 5'($urandom_range(0, 23));
    end
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    compare_all();
  endtask

  task automatic run_ticks(input int n, input logic req);
    for (int i = 0; i < n; i++) begin
      cycle(req, 1'b0, 1'b0, 1'b0);
      cycle(req, 1'b0, 1'b0, 1'b0);
      cycle(req, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    logic req_lvl;
    rst = 1'b1;
    model_reset();
    tick_1khz = 0; btn_mode = 0; btn_page = 0; alarm_req = 0;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    rst = 1'b0;

    phase = "pre_reset";
    for (int i = 0; i < 60; i++)
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));

    phase = "reset";
    rst = 1'b1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    rst = 1'b0;
    check_val("owner0", owner, 0);
    check_val("gnt0", alarm_gnt, 0);
    hold_data = 1'b1;
    w_sec = 6'd42; w_msec = 7'd17;
    cycle(0, 0, 0, 0);
    check_val("sec42", sec, 42);
    check_val("msec17", msec, 17);
    hold_data = 1'b0;

    phase = "mode_page";
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    check_val("page1", page, 1);
    cycle(0, 1, 0, 0);
    check_val("owner_back", owner, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 0);
    check_val("mode_wins", page, 0);

    phase = "preempt";
    cycle(0, 0, 1, 0);
    run_ticks(2, 1);
    run_ticks(6, 0);
    check_val("ret_owner", owner, 1);
    check_val("ret_page", page, 1);

    phase = "extend_blink";
    run_ticks(12, 1);
    run_ticks(1, 0);
    check_val("exit_blank", blank, 0);

    phase = "btn_drop";
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 1);
    cycle(0, 1, 0, 0);
    run_ticks(6, 0);

    phase = "async_rst";
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    check_val("async_gnt", alarm_gnt, 0);
    cycle(0, 0, 0, 0);
    rst = 1'b0;

    phase = "auto_page";
    run_ticks(1, 0);
    cycle(0, 0, 1, 1);
    run_ticks(20, 0);

    phase = "random";
    req_lvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) req_lvl = ~req_lvl;
      cycle(req_lvl, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
